// File: rtl/dqs_mode_sequencer.sv
// Mode sequencer for the DQS pattern stage: turns write bursts and write-leveling
// commands into a registered idle/preamble/transmit/postamble/wlevel mode stream.
module dqs_mode_sequencer #(
  parameter int unsigned PRE_CYCLES  = 1,
  parameter int unsigned POST_CYCLES = 1,
  parameter int unsigned LEN_W       = 6,
  parameter int unsigned WL_GAP      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [LEN_W-1:0] i_wr_len,
  input  logic             i_wl_start,
  input  logic [7:0]       i_wl_pulses,
  input  logic             i_wl_abort,
  output logic [3:0]       o_mode,
  output logic             o_busy,
  output logic             o_wl_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_POST, S_WL_EN, S_WL_STB
  } state_t;

  localparam logic [15:0] PRE_LD  = 16'(PRE_CYCLES - 1);
  localparam logic [15:0] POST_LD = 16'(POST_CYCLES - 1);
  localparam logic [15:0] GAP_LD  = 16'(WL_GAP - 1);

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_pcnt, w_pcnt_nxt;
  logic [LEN_W-1:0] r_dcnt, w_dcnt_nxt;
  logic [7:0]       r_scnt, w_scnt_nxt;
  logic [3:0]       r_mode, w_mode_nxt;
  logic             r_busy, r_wl_done, w_done_nxt;
  logic [LEN_W-1:0] w_len_ld;

  assign w_len_ld   = (i_wr_len == '0) ? LEN_W'(1) : i_wr_len;
  assign o_wr_ready = ((r_state == S_IDLE) && !i_wl_start) ||
                      ((r_state == S_DATA) && (r_dcnt == LEN_W'(1)));
  assign o_mode     = r_mode;
  assign o_busy     = r_busy;
  assign o_wl_done  = r_wl_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_pcnt    <= '0;
      r_dcnt    <= '0;
      r_scnt    <= '0;
      r_mode    <= '0;
      r_busy    <= 1'b0;
      r_wl_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_scnt    <= w_scnt_nxt;
      r_mode    <= w_mode_nxt;
      r_busy    <= (w_mode_nxt != 4'd0);
      r_wl_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_dcnt_nxt  = r_dcnt;
    w_scnt_nxt  = r_scnt;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_wl_start) begin
          w_state_nxt = S_WL_EN;
          w_pcnt_nxt  = GAP_LD;
          w_scnt_nxt  = i_wl_pulses;
        end else if (i_wr_valid) begin
          w_state_nxt = S_PRE;
          w_pcnt_nxt  = PRE_LD;
          w_dcnt_nxt  = w_len_ld;
        end
      end
      S_PRE: begin
        if (r_pcnt == '0) w_state_nxt = S_DATA;
        else              w_pcnt_nxt  = r_pcnt - 16'd1;
      end
      S_DATA: begin
        // Last data cycle doubles as an accept slot for back-to-back bursts.
        if (r_dcnt == LEN_W'(1)) begin
          if (i_wr_valid) begin
            w_dcnt_nxt = w_len_ld;
          end else begin
            w_state_nxt = S_POST;
            w_pcnt_nxt  = POST_LD;
            w_dcnt_nxt  = '0;
          end
        end else begin
          w_dcnt_nxt = r_dcnt - LEN_W'(1);
        end
      end
      S_POST: begin
        if (r_pcnt == '0) w_state_nxt = S_IDLE;
        else              w_pcnt_nxt  = r_pcnt - 16'd1;
      end
      S_WL_EN: begin
        if (i_wl_abort) begin
          w_state_nxt = S_IDLE;
          w_pcnt_nxt  = '0;
          w_scnt_nxt  = '0;
        end else if (r_pcnt != '0) begin
          w_pcnt_nxt = r_pcnt - 16'd1;
        end else if (r_scnt == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_WL_STB;
        end
      end
      S_WL_STB: begin
        if (i_wl_abort) begin
          w_state_nxt = S_IDLE;
          w_pcnt_nxt  = '0;
          w_scnt_nxt  = '0;
        end else begin
          w_state_nxt = S_WL_EN;
          w_pcnt_nxt  = GAP_LD;
          w_scnt_nxt  = r_scnt - 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mode_nxt = 4'd0;
    unique case (w_state_nxt)
      S_IDLE:   w_mode_nxt = 4'd0;
      S_DATA:   w_mode_nxt = 4'd1;
      S_PRE:    w_mode_nxt = 4'd2;
      S_POST:   w_mode_nxt = 4'd3;
      S_WL_EN:  w_mode_nxt = 4'd4;
      S_WL_STB: w_mode_nxt = 4'd5;
      default:  w_mode_nxt = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_dqs_mode_sequencer.sv
// Self-checking bench for dqs_mode_sequencer: per-cycle vector table with a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_dqs_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_len;
  logic       wl_start;
  logic [7:0] wl_pulses;
  logic       wl_abort;
  logic [3:0] mode;
  logic       busy;
  logic       wl_done;

  dqs_mode_sequencer #(
    .PRE_CYCLES(1), .POST_CYCLES(1), .LEN_W(6), .WL_GAP(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_len(wr_len),
    .i_wl_start(wl_start), .i_wl_pulses(wl_pulses), .i_wl_abort(wl_abort),
    .o_mode(mode), .o_busy(busy), .o_wl_done(wl_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [5:0] len;
    logic       ws;
    logic [7:0] pl;
    logic       ab;
    logic       er;
    logic [3:0] em;
    logic       ed;
  } vec_t;

  typedef struct {
    logic       er;
    logic [3:0] em;
    logic       eb;
    logic       ed;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic cmp(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  // One cycle: inputs driven in this cycle, outputs expected in this cycle.
  task automatic add(input int v, input int len, input int ws, input int pl,
                     input int ab, input int er, input int em, input int ed);
    vec_t t;
    t.v = v[0]; t.len = len[5:0]; t.ws = ws[0]; t.pl = pl[7:0]; t.ab = ab[0];
    t.er = er[0]; t.em = em[3:0]; t.ed = ed[0];
    tbl.push_back(t);
  endtask

  task automatic addn(input int n, input int v, input int len, input int ws,
                      input int pl, input int ab, input int er, input int em);
    for (int k = 0; k < n; k++) add(v, len, ws, pl, ab, er, em, 0);
  endtask

  task automatic run_table(input string tag);
    exp_t e;
    exp_t g;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      wr_valid  = tbl[i].v;
      wr_len    = tbl[i].len;
      wl_start  = tbl[i].ws;
      wl_pulses = tbl[i].pl;
      wl_abort  = tbl[i].ab;
      e.er = tbl[i].er; e.em = tbl[i].em; e.eb = (tbl[i].em != 4'd0); e.ed = tbl[i].ed;
      sb.push_back(e);
      #1;
      g = sb.pop_front();
      cmp({tag, " mode"},  i, 8'(mode),     8'(g.em));
      cmp({tag, " busy"},  i, 8'(busy),     8'(g.eb));
      cmp({tag, " done"},  i, 8'(wl_done),  8'(g.ed));
      cmp({tag, " ready"}, i, 8'(wr_ready), 8'(g.er));
    end
    tbl.delete();
    @(negedge clk);
    wr_valid = 1'b0; wl_start = 1'b0; wl_abort = 1'b0;
  endtask

  task automatic add_single_burst();
    add(1, 4, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2, 0);
    addn(3, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_len = '0;
    wl_start = 1'b0; wl_pulses = '0; wl_abort = 1'b0;
    #2;
    cmp("rst mode",  0, 8'(mode),     8'd0);
    cmp("rst busy",  0, 8'(busy),     8'd0);
    cmp("rst done",  0, 8'(wl_done),  8'd0);
    cmp("rst ready", 0, 8'(wr_ready), 8'd1);
    wl_start = 1'b1;
    #1;
    cmp("rst ready wl", 0, 8'(wr_ready), 8'd0);
    wl_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // single burst len=4
    add_single_burst();
    // seamless len=2 then len=3
    add(1, 2, 0, 0, 0, 1, 0, 0);
    add(1, 3, 0, 0, 0, 0, 2, 0);
    add(1, 3, 0, 0, 0, 0, 1, 0);
    add(1, 3, 0, 0, 0, 1, 1, 0);
    addn(2, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    // len=0 treated as 1
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    // write leveling, 2 pulses
    add(0, 0, 1, 2, 0, 0, 0, 0);
    addn(4, 0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 5, 0);
    addn(4, 0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 5, 0);
    addn(4, 0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    // write leveling, 0 pulses
    add(0, 0, 1, 0, 0, 0, 0, 0);
    addn(4, 0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 1, 0, 1);
    // wl_start and wr_valid together: WL wins, write accepted on return to IDLE
    add(1, 2, 1, 1, 0, 0, 0, 0);
    addn(4, 1, 2, 0, 0, 0, 0, 4);
    add(1, 2, 0, 0, 0, 0, 5, 0);
    addn(4, 1, 2, 0, 0, 0, 0, 4);
    add(1, 2, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0);
    add(0, 0, 1, 7, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    // abort during second WL_EN run; abort ignored in IDLE and write states
    add(0, 0, 1, 2, 0, 0, 0, 0);
    addn(4, 0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 5, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0, 1, 0, 4, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 2, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 3, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    run_table("tbl");

    // asynchronous reset in the middle of DATA
    @(negedge clk); wr_valid = 1'b1; wr_len = 6'd8;
    @(negedge clk); wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    cmp("pre-rst mode", 0, 8'(mode), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async rst mode",  0, 8'(mode),     8'd0);
    cmp("async rst busy",  0, 8'(busy),     8'd0);
    cmp("async rst ready", 0, 8'(wr_ready), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    add_single_burst();
    run_table("post-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
